nv_nvdla_cdma_wrr_arb_nch: RTL and testbench

//  Parametrised N-channel weighted round-robin arbiter for CDMA read-request paths.
//  - Each requester holds the grant for up to wt[i] consecutive accepted grants, then
//    the grant rotates to the next eligible requester.
//  - Grant is combinational from current state and inputs. State advances only on

---
 rtl/nv_nvdla_cdma_wrr_arb_nch.sv | 112 +++++++++++
 tb/tb_nv_nvdla_cdma_wrr_arb_nch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cdma_wrr_arb_nch.sv
// N-channel weighted round-robin arbiter for CDMA read requests; combinational grant.
// Optional urgent bypass enabled by defining NV_CDMA_WRR_URG_EN.
module nv_nvdla_cdma_wrr_arb_nch #(
  parameter  int NUM_REQ = 4,
  parameter  int WT_W    = 5,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*WT_W-1:0] wt,
  input  logic                    gnt_busy,
`ifdef NV_CDMA_WRR_URG_EN
  input  logic [NUM_REQ-1:0]      urg,
`endif
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    gnt_vld,
  output logic [IDX_W-1:0]        gnt_id
);

  logic [NUM_REQ-1:0] r_last_gnt;
  logic [WT_W-1:0]    r_wt_left;

  logic [NUM_REQ-1:0] w_eff_req;
  logic [IDX_W-1:0]   w_last_idx;
  logic               w_hold;
  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [WT_W-1:0]    w_rr_wt;
  logic [NUM_REQ-1:0] w_gnt_pre;
  logic [WT_W-1:0]    w_wt_left_nxt;
  logic [NUM_REQ-1:0] w_gnt_sel;
  logic               w_urg_act;

  always_comb begin
    w_eff_req = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_eff_req[i] = req[i] & (wt[i*WT_W +: WT_W] != '0);
  end

  always_comb begin
    w_last_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (r_last_gnt[i]) w_last_idx = IDX_W'(i);
  end

  assign w_hold = (r_wt_left != '0) & (|(w_eff_req & r_last_gnt));

  // Search begins one past the previous winner, or at channel 0 when nothing was granted yet.
  always_comb begin
    int  start;
    int  c;
    logic found;
    w_rr_gnt = '0;
    w_rr_wt  = '0;
    found    = 1'b0;
    c        = 0;
    start    = (r_last_gnt == '0) ? 0 : int'(w_last_idx) + 1;
    if (start >= NUM_REQ) start = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = start + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && w_eff_req[c]) begin
        found       = 1'b1;
        w_rr_gnt[c] = 1'b1;
        w_rr_wt     = wt[c*WT_W +: WT_W];
      end
    end
  end

  always_comb begin
    w_gnt_pre     = w_rr_gnt;
    w_wt_left_nxt = r_wt_left;
    if (w_hold) begin
      w_gnt_pre     = r_last_gnt;
      w_wt_left_nxt = r_wt_left - WT_W'(1);
    end else if (w_rr_wt != '0) begin
      w_wt_left_nxt = w_rr_wt - WT_W'(1);
    end
  end

`ifdef NV_CDMA_WRR_URG_EN
  logic [NUM_REQ-1:0] w_urg_eff;
  assign w_urg_eff = urg & w_eff_req;
  assign w_urg_act = |w_urg_eff;
  // Isolate the lowest set bit: lowest-index urgent channel wins.
  assign w_gnt_sel = w_urg_act ? (w_urg_eff & (~w_urg_eff + NUM_REQ'(1))) : w_gnt_pre;
`else
  assign w_urg_act = 1'b0;
  assign w_gnt_sel = w_gnt_pre;
`endif

  assign gnt     = w_gnt_sel & {NUM_REQ{~gnt_busy}};
  assign gnt_vld = |gnt;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_id = IDX_W'(i);
  end

  // Urgent grants bypass the WRR state entirely.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_last_gnt <= '0;
      r_wt_left  <= '0;
    end else if (~gnt_busy & (|w_eff_req) & ~w_urg_act) begin
      r_last_gnt <= w_gnt_pre;
      r_wt_left  <= w_wt_left_nxt;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cdma_wrr_arb_nch.sv
// Directed bench for the 4-channel WRR arbiter; expected grant sequences are hand-derived.
module tb_nv_nvdla_cdma_wrr_arb_nch;

  logic        clk;
  logic        reset_;
  logic [3:0]  req;
  logic [19:0] wt;
  logic        gnt_busy;
  logic [3:0]  urg;
  logic [3:0]  gnt;
  logic        gnt_vld;
  logic [1:0]  gnt_id;

  int n_vec = 0;
  int n_err = 0;

  int s1[13] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0, 1, 1};
  int s2[6]  = '{0, 1, 3, 0, 1, 3};
  int s3[9]  = '{0, 1, 2, -1, -1, -1, 2, 3, 0};
  int s4a[3] = '{0, 1, 1};
  int s4b[6] = '{2, 2, 2, 3, 0, 2};
  int s5[4]  = '{0, 3, 0, 3};
  int s6[7]  = '{0, 1, 1, 2, 2, 2, 3};

  nv_nvdla_cdma_wrr_arb_nch #(.NUM_REQ(4), .WT_W(5)) dut (
    .clk      (clk),
    .reset_   (reset_),
    .req      (req),
    .wt       (wt),
    .gnt_busy (gnt_busy),
`ifdef NV_CDMA_WRR_URG_EN
    .urg      (urg),
`endif
    .gnt      (gnt),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the combinational grant for the current cycle, then advances one clock.
  task automatic step(input string tag, input int exp_id);
    #1;
    if (exp_id < 0) begin
      chk({tag, "_vld"}, gnt_vld, 0);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_id"}, gnt_id, 0);
    end else begin
      chk({tag, "_vld"}, gnt_vld, 1);
      chk({tag, "_gnt"}, gnt, 32'(1) << exp_id);
      chk({tag, "_id"}, gnt_id, exp_id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  initial begin
    reset_   = 1'b0;
    req      = '0;
    wt       = '0;
    gnt_busy = 1'b0;
    urg      = '0;
    #2;
    chk("rst_vld", gnt_vld, 0);
    do_reset();
    step("rst_idle", -1);

    // 1: weights 4,3,2,1
    wt = {5'd4, 5'd3, 5'd2, 5'd1}; req = 4'hF;
    do_reset();
    foreach (s1[i]) step($sformatf("t1_%0d", i), s1[i]);

    // 2: zero weight on ch2 masks it
    wt = {5'd1, 5'd0, 5'd1, 5'd1};
    do_reset();
    foreach (s2[i]) step($sformatf("t2_%0d", i), s2[i]);

    // 3: busy mid ch2 burst
    wt = {5'd1, 5'd2, 5'd1, 5'd1};
    do_reset();
    foreach (s3[i]) begin
      gnt_busy = (i >= 3 && i <= 5);
      step($sformatf("t3_%0d", i), s3[i]);
    end
    gnt_busy = 1'b0;

    // 4: ch1 drops mid-burst, ch2 takes over with full weight
    wt = {5'd1, 5'd3, 5'd4, 5'd1};
    do_reset();
    foreach (s4a[i]) step($sformatf("t4a_%0d", i), s4a[i]);
    req = 4'b1101;
    foreach (s4b[i]) step($sformatf("t4b_%0d", i), s4b[i]);

    // 5: wrap-around between ch3 and ch0
    wt = {5'd1, 5'd1, 5'd1, 5'd1}; req = 4'b1001;
    do_reset();
    foreach (s5[i]) step($sformatf("t5_%0d", i), s5[i]);

    // weight change mid-burst keeps burst length; change to 0 masks at once
    wt = {5'd3, 5'd1, 5'd1, 5'd1}; req = 4'b1001;
    do_reset();
    step("wc_0", 0);
    step("wc_1", 3);
    wt[19:15] = 5'd1;
    step("wc_2", 3);
    step("wc_3", 3);
    step("wc_4", 0);
    wt[19:15] = 5'd3;
    step("wc_5", 3);
    wt[19:15] = 5'd0;
    step("wc_6", 0);

    // single requester re-granted continuously
    wt = {5'd1, 5'd2, 5'd1, 5'd1}; req = 4'b0100;
    do_reset();
    for (int i = 0; i < 5; i++) step($sformatf("single_%0d", i), 2);

    // 6: reset during ch3 burst
    wt = {5'd4, 5'd3, 5'd2, 5'd1}; req = 4'hF;
    do_reset();
    foreach (s6[i]) step($sformatf("t6_%0d", i), s6[i]);
    do_reset();
    step("t6_post_0", 0);
    step("t6_post_1", 1);

`ifdef NV_CDMA_WRR_URG_EN
    wt = {5'd1, 5'd1, 5'd3, 5'd1}; req = 4'hF;
    do_reset();
    step("urg_0", 0);
    step("urg_1", 1);
    urg = 4'b0100;
    step("urg_2", 2);
    urg = 4'b0000;
    step("urg_3", 1);
    step("urg_4", 1);
    step("urg_5", 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
